// File: rtl/bit_deserializer.sv
// Bit-serial to word-parallel converter with a one-word holding register
// and a valid/ready handshake toward the downstream word register.
module bit_deserializer #(
    parameter int unsigned WIDTH     = 16,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4:0]       bit_count
);

    localparam int unsigned CW = 5;
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    logic [WIDTH-1:0] shift;
    logic [WIDTH-1:0] next_shift;
    logic             last_bit;
    logic             accept;
    logic             load;

    // Stall only when the completing bit would find the holding register occupied.
    assign last_bit = (bit_count == LAST_IDX);
    assign in_ready = !(out_valid && !out_ready && last_bit);
    assign accept   = in_valid && in_ready && !clear;
    assign load     = accept && last_bit;

    // Bit placement within the partial word.
    always_comb begin
        next_shift = shift;
        if (MSB_FIRST) begin
            next_shift = {shift[WIDTH-2:0], in};
        end else begin
            next_shift = {in, shift[WIDTH-1:1]};
        end
    end

    // Partial-word assembly; clear discards it but leaves the held word alone.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shift     <= '0;
            bit_count <= '0;
        end else if (clear) begin
            bit_count <= '0;
        end else if (accept) begin
            shift <= next_shift;
            if (last_bit) begin
                bit_count <= '0;
            end else begin
                bit_count <= bit_count + CW'(1);
            end
        end
    end

    // Holding register: a same-edge consume and load keeps out_valid high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out       <= '0;
            out_valid <= 1'b0;
        end else if (load) begin
            out       <= next_shift;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bit_deserializer.sv
// Directed self-checking bench for bit_deserializer (MSB-first and LSB-first instances).
module tb_bit_deserializer;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic        in;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  bit_count;

    logic        clear2;
    logic        in2;
    logic        in_valid2;
    logic        in_ready2;
    logic [15:0] out2;
    logic        out_valid2;
    logic        out_ready2;
    logic [4:0]  bit_count2;

    int total;
    int bad;

    bit_deserializer #(.WIDTH(16), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in(in), .in_valid(in_valid),
        .in_ready(in_ready), .out(out), .out_valid(out_valid),
        .out_ready(out_ready), .bit_count(bit_count)
    );

    bit_deserializer #(.WIDTH(16), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst_n(rst_n), .clear(clear2), .in(in2), .in_valid(in_valid2),
        .in_ready(in_ready2), .out(out2), .out_valid(out_valid2),
        .out_ready(out_ready2), .bit_count(bit_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present nbits of word MSB-first on the MSB-first instance, one per cycle.
    task automatic send_msb(input logic [15:0] word, input int nbits);
        for (int i = 15; i > 15 - nbits; i--) begin
            in       = word[i];
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        total++;
        if (bit_count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", bit_count); end
        total++;
        if (out !== 16'h0000) begin bad++; $display("FAIL reset_out got=%h want=0000", out); end
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_msb_first();
        logic [15:0] w;
        w = 16'hA5C3;
        out_ready = 1'b1;
        for (int i = 15; i >= 0; i--) begin
            in       = w[i];
            in_valid = 1'b1;
            total++;
            if (bit_count !== 5'(15 - i)) begin
                bad++; $display("FAIL msb_count got=%0d want=%0d", bit_count, 15 - i);
            end
            total++;
            if (out_valid !== 1'b0) begin bad++; $display("FAIL msb_early_valid at bit %0d", 15 - i); end
            tick();
        end
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1 || out !== 16'hA5C3) begin
            bad++; $display("FAIL msb_word got=%h/%b want=a5c3/1", out, out_valid);
        end
        total++;
        if (bit_count !== 5'd0) begin bad++; $display("FAIL msb_wrap got=%0d want=0", bit_count); end
        tick();
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL msb_pulse_len got=%b want=0", out_valid); end
    endtask

    task automatic test_lsb_first();
        logic [15:0] w;
        w = 16'hA5C3;
        out_ready2 = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in2       = w[i];
            in_valid2 = 1'b1;
            tick();
        end
        in_valid2 = 1'b0;
        total++;
        if (out_valid2 !== 1'b1 || out2 !== 16'hA5C3) begin
            bad++; $display("FAIL lsb_word got=%h/%b want=a5c3/1", out2, out_valid2);
        end
        tick();
        total++;
        if (out_valid2 !== 1'b0) begin bad++; $display("FAIL lsb_pulse_len got=%b want=0", out_valid2); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        send_msb(16'h1234, 16);
        total++;
        if (out_valid !== 1'b1 || out !== 16'h1234) begin
            bad++; $display("FAIL bp_first got=%h/%b want=1234/1", out, out_valid);
        end
        send_msb(16'hFFFF, 15);
        in       = 1'b1;
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            total++;
            if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready got=%b want=0", in_ready); end
            tick();
            total++;
            if (bit_count !== 5'd15 || out !== 16'h1234 || out_valid !== 1'b1) begin
                bad++; $display("FAIL bp_hold got=%0d/%h/%b want=15/1234/1", bit_count, out, out_valid);
            end
        end
        out_ready = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release got=%b want=1", in_ready); end
        tick();
        in_valid = 1'b0;
        total++;
        if (out !== 16'hFFFF || out_valid !== 1'b1 || bit_count !== 5'd0) begin
            bad++; $display("FAIL bp_second got=%h/%b/%0d want=ffff/1/0", out, out_valid, bit_count);
        end
        tick();
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got=%b want=0", out_valid); end
    endtask

    task automatic test_clear();
        out_ready = 1'b1;
        send_msb(16'hFFFF, 7);
        total++;
        if (bit_count !== 5'd7) begin bad++; $display("FAIL clr_pre got=%0d want=7", bit_count); end
        clear    = 1'b1;
        in       = 1'b1;
        in_valid = 1'b1;
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        total++;
        if (bit_count !== 5'd0 || out !== 16'hFFFF || out_valid !== 1'b0) begin
            bad++; $display("FAIL clr_state got=%0d/%h/%b want=0/ffff/0", bit_count, out, out_valid);
        end
        send_msb(16'h00FF, 16);
        total++;
        if (out !== 16'h00FF || out_valid !== 1'b1) begin
            bad++; $display("FAIL clr_word got=%h/%b want=00ff/1", out, out_valid);
        end
        tick();
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b1;
        send_msb(16'h3333, 10);
        rst_n    = 1'b0;
        in       = 1'b1;
        in_valid = 1'b1;
        tick();
        rst_n    = 1'b1;
        in_valid = 1'b0;
        total++;
        if (bit_count !== 5'd0 || out !== 16'h0000 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL rst_mid got=%0d/%h/%b/%b want=0/0000/0/1",
                            bit_count, out, out_valid, in_ready);
        end
        send_msb(16'hBEEF, 16);
        total++;
        if (out !== 16'hBEEF || out_valid !== 1'b1) begin
            bad++; $display("FAIL rst_word got=%h/%b want=beef/1", out, out_valid);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [47:0] stream;
        logic [15:0] words [3];
        int          pulses;
        stream   = 48'hAAAA_5555_0F0F;
        words[0] = 16'hAAAA;
        words[1] = 16'h5555;
        words[2] = 16'h0F0F;
        pulses   = 0;
        out_ready = 1'b1;
        for (int k = 0; k < 48; k++) begin
            in       = stream[47 - k];
            in_valid = 1'b1;
            total++;
            if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready cycle=%0d got=0 want=1", k); end
            tick();
            if (out_valid === 1'b1) begin
                total++;
                if (k != pulses * 16 + 15 || pulses > 2) begin
                    bad++; $display("FAIL b2b_spacing cycle=%0d pulse=%0d want_cycle=%0d", k, pulses, pulses * 16 + 15);
                end else begin
                    total++;
                    if (out !== words[pulses]) begin
                        bad++; $display("FAIL b2b_word got=%h want=%h", out, words[pulses]);
                    end
                end
                pulses++;
            end
        end
        in_valid = 1'b0;
        total++;
        if (pulses != 3) begin bad++; $display("FAIL b2b_pulses got=%0d want=3", pulses); end
        tick();
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_tail got=%b want=0", out_valid); end
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        rst_n      = 1'b0;
        clear      = 1'b0;
        in         = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        clear2     = 1'b0;
        in2        = 1'b0;
        in_valid2  = 1'b0;
        out_ready2 = 1'b0;
        test_reset();
        test_msb_first();
        test_lsb_first();
        test_backpressure();
        test_clear();
        test_mid_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
